// File: rtl/chirp_writer_pkg.sv
// Shared types and constants for the chirp result writer and its elastic buffer.
package chirp_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int BEAT_CNT_W         = 11;
  localparam int CHIRP_CNT_W        = 10;

  typedef logic [BEAT_CNT_W-1:0]  beat_cnt_t;
  typedef logic [CHIRP_CNT_W-1:0] chirp_cnt_t;

  function automatic logic last_beat(input beat_cnt_t idx, input beat_cnt_t cnt);
    return idx == (cnt - BEAT_CNT_W'(1));
  endfunction

  function automatic logic last_chirp(input chirp_cnt_t idx, input chirp_cnt_t cnt);
    return idx == (cnt - CHIRP_CNT_W'(1));
  endfunction

endpackage

// File: rtl/cw_fifo.sv
// Elastic buffer for processed beats: synchronous push/pop, head word held in
// its own register so the RAM write data never comes from the storage mux.
module cw_fifo
  import chirp_writer_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign o_empty    = (count_q == '0);
  assign o_full     = (count_q == (PTR_W+1)'(DEPTH));
  assign o_rd_data  = head_q;
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

  // A pop frees a slot in the same cycle, so a full buffer still accepts a push.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_nxt;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    if (do_pop) begin
      if (count_q > (PTR_W+1)'(1)) head_d = mem_q[rd_ptr_nxt];
      else if (do_push)            head_d = i_wr_data;
    end else if (do_push && o_empty) begin
      head_d = i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wr_data;
  end

endmodule

// File: rtl/chirp_result_writer.sv
// Writes one frame of processed chirp beats into RAM: buffers the non-stallable
// upstream, generates chirp-strided addresses and reports chirp/frame completion.
module chirp_result_writer
  import chirp_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [BEAT_CNT_W-1:0] i_beat_cnt,
  input  logic [CHIRP_CNT_W-1:0] i_chirp_cnt,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_chirp_stride,
  input  logic [DATA_WIDTH-1:0] i_y0,
  input  logic                  i_y0_valid,
  input  logic                  i_wr_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_busy,
  output logic                  o_chirp_done,
  output logic                  o_frame_done,
  output logic                  o_ovf,
  output logic                  o_unexp
);

  state_e                state_q, state_d;
  beat_cnt_t             beat_cnt_q, beat_cnt_d;
  chirp_cnt_t            chirp_cnt_q, chirp_cnt_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  beat_cnt_t             in_beat_q, in_beat_d;
  chirp_cnt_t            in_chirp_q, in_chirp_d;
  beat_cnt_t             out_beat_q, out_beat_d;
  chirp_cnt_t            out_chirp_q, out_chirp_d;
  logic [ADDR_WIDTH-1:0] chirp_start_q, chirp_start_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ovf_q, ovf_d;
  logic                  unexp_q, unexp_d;
  logic                  chirp_done_q, chirp_done_d;
  logic                  frame_done_q, frame_done_d;

  logic                  fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  wr_fire, push_ok;
  logic                  in_last_beat, in_last, out_last_beat, out_last;

  // The buffer head is the pending RAM write, so o_wr_en is simply "not empty".
  assign wr_fire       = !fifo_empty && i_wr_ready;
  assign push_ok       = (state_q == ST_RUN) && i_y0_valid && (!fifo_full || wr_fire);
  assign in_last_beat  = last_beat(in_beat_q, beat_cnt_q);
  assign in_last       = in_last_beat && last_chirp(in_chirp_q, chirp_cnt_q);
  assign out_last_beat = last_beat(out_beat_q, beat_cnt_q);
  assign out_last      = out_last_beat && last_chirp(out_chirp_q, chirp_cnt_q);

  cw_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (push_ok),
    .i_wr_data (i_y0),
    .i_pop     (wr_fire),
    .o_rd_data (fifo_head),
    .o_empty   (fifo_empty),
    .o_full    (fifo_full)
  );

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    chirp_cnt_d   = chirp_cnt_q;
    stride_d      = stride_q;
    in_beat_d     = in_beat_q;
    in_chirp_d    = in_chirp_q;
    out_beat_d    = out_beat_q;
    out_chirp_d   = out_chirp_q;
    chirp_start_d = chirp_start_q;
    addr_d        = addr_q;
    ovf_d         = ovf_q;
    unexp_d       = unexp_q;
    chirp_done_d  = 1'b0;
    frame_done_d  = 1'b0;

    // Address follows the write side; the chirp-start accumulator replaces chirp_idx*stride.
    if (wr_fire) begin
      chirp_done_d = out_last_beat;
      frame_done_d = out_last;
      if (out_last_beat) begin
        out_beat_d    = '0;
        out_chirp_d   = out_chirp_q + CHIRP_CNT_W'(1);
        chirp_start_d = chirp_start_q + stride_q;
        addr_d        = chirp_start_q + stride_q;
      end else begin
        out_beat_d = out_beat_q + BEAT_CNT_W'(1);
        addr_d     = addr_q + ADDR_WIDTH'(1);
      end
    end

    if (push_ok) begin
      if (in_last_beat) begin
        in_beat_d  = '0;
        in_chirp_d = in_chirp_q + CHIRP_CNT_W'(1);
      end else begin
        in_beat_d = in_beat_q + BEAT_CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d       = ST_RUN;
          beat_cnt_d    = i_beat_cnt;
          chirp_cnt_d   = i_chirp_cnt;
          stride_d      = i_chirp_stride;
          chirp_start_d = i_base_addr;
          addr_d        = i_base_addr;
          in_beat_d     = '0;
          in_chirp_d    = '0;
          out_beat_d    = '0;
          out_chirp_d   = '0;
          ovf_d         = 1'b0;
          unexp_d       = 1'b0;
        end
      end
      ST_RUN:   if (push_ok && in_last)  state_d = ST_FLUSH;
      ST_FLUSH: if (wr_fire && out_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A beat landing in the start cycle still counts as unexpected.
    if (i_y0_valid) begin
      if (state_q != ST_RUN) unexp_d = 1'b1;
      else if (!push_ok)     ovf_d   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= '0;
      chirp_cnt_q   <= '0;
      stride_q      <= '0;
      in_beat_q     <= '0;
      in_chirp_q    <= '0;
      out_beat_q    <= '0;
      out_chirp_q   <= '0;
      chirp_start_q <= '0;
      addr_q        <= '0;
      ovf_q         <= 1'b0;
      unexp_q       <= 1'b0;
      chirp_done_q  <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      chirp_cnt_q   <= chirp_cnt_d;
      stride_q      <= stride_d;
      in_beat_q     <= in_beat_d;
      in_chirp_q    <= in_chirp_d;
      out_beat_q    <= out_beat_d;
      out_chirp_q   <= out_chirp_d;
      chirp_start_q <= chirp_start_d;
      addr_q        <= addr_d;
      ovf_q         <= ovf_d;
      unexp_q       <= unexp_d;
      chirp_done_q  <= chirp_done_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign o_wr_en      = !fifo_empty;
  assign o_wr_addr    = addr_q;
  assign o_wr_data    = fifo_head;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_chirp_done = chirp_done_q;
  assign o_frame_done = frame_done_q;
  assign o_ovf        = ovf_q;
  assign o_unexp      = unexp_q;

endmodule
